// File: rtl/tri_bus_reader.sv
// Samples a shared tristate bus once per stable one-hot driver enable and
// queues {driver index, data} captures in a small FIFO for a downstream consumer.
module tri_bus_reader #(
    parameter int unsigned DW     = 8,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] bus_data,
    input  logic [1:0]    bus_en,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overflow,
    output logic          contention,
    input  logic          clr_err
);

    localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = AW + 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            src_q, src_d;
    logic            cap_c;
    logic            cont_set_c;

    logic [DW-1:0]   mem_data [DEPTH];
    logic            mem_src  [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_nxt_c;
    logic [NW-1:0]   count_q, count_d;
    logic [DW-1:0]   head_data_q, head_data_d;
    logic            head_src_q, head_src_d;
    logic            valid_q;
    logic            ovf_q, cont_q;
    logic            pop_c, push_c, full_c, ovf_set_c;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    // Next-state: contention overrides everything, otherwise track enable stability
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        cap_c      = 1'b0;
        cont_set_c = 1'b0;
        if (bus_en == 2'b11) begin
            cont_set_c = 1'b1;
            state_d    = S_HOLD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus_en != 2'b00) begin
                        src_d   = bus_en[1];
                        cnt_d   = CW'(1);
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (bus_en == (src_q ? 2'b10 : 2'b01)) begin
                        if (cnt_q == CW'(SETTLE)) begin
                            cap_c   = 1'b1;
                            state_d = S_HOLD;
                        end else begin
                            cnt_d = CW'(cnt_q + CW'(1));
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (bus_en == 2'b00) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign pop_c     = valid_q && out_ready;
    assign full_c    = (count_q == NW'(DEPTH));
    assign push_c    = cap_c && (!full_c || pop_c);
    assign ovf_set_c = cap_c && full_c && !pop_c;
    assign rd_nxt_c  = AW'(rd_ptr_q + AW'(1));

    // Head register tracks the entry that will sit at the read pointer after this edge
    always_comb begin
        count_d     = NW'(count_q + NW'(push_c) - NW'(pop_c));
        head_data_d = head_data_q;
        head_src_d  = head_src_q;
        if (push_c && ((count_q == '0) || (pop_c && count_q == NW'(1)))) begin
            head_data_d = bus_data;
            head_src_d  = src_q;
        end else if (pop_c) begin
            head_data_d = mem_data[rd_nxt_c];
            head_src_d  = mem_src[rd_nxt_c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_src[i]  <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_data_q <= '0;
            head_src_q  <= 1'b0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cont_q      <= 1'b0;
        end else begin
            if (push_c) begin
                mem_data[wr_ptr_q] <= bus_data;
                mem_src[wr_ptr_q]  <= src_q;
                wr_ptr_q           <= AW'(wr_ptr_q + AW'(1));
            end
            if (pop_c) begin
                rd_ptr_q <= rd_nxt_c;
            end
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_src_q  <= head_src_d;
            valid_q     <= (count_d != '0);
            // Set beats clear when both happen in the same cycle
            ovf_q  <= ovf_set_c  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
            cont_q <= cont_set_c ? 1'b1 : (clr_err ? 1'b0 : cont_q);
        end
    end

    assign out_data   = head_data_q;
    assign out_src    = head_src_q;
    assign out_valid  = valid_q;
    assign overflow   = ovf_q;
    assign contention = cont_q;

endmodule

// File: tb/tb_tri_bus_reader.sv
// Bench for tri_bus_reader: per-cycle vector table plus hand-written FIFO,
// overflow and reset sequences; popped entries are checked against a queue.
module tb_tri_bus_reader;

    localparam int DW     = 8;
    localparam int SETTLE = 2;
    localparam int DEPTH  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] bus_data;
    logic [1:0]    bus_en;
    logic [DW-1:0] out_data;
    logic          out_src;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          contention;
    logic          clr_err;

    tri_bus_reader #(.DW(DW), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .bus_en(bus_en),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .contention(contention),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DW:0] sb_q [$];
    logic [DW:0] mon_exp;

    typedef struct {
        logic [1:0]    en;
        logic [DW-1:0] data;
        logic          clr;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_src;
        logic          e_ovf;
        logic          e_cont;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [1:0] en, input logic [DW-1:0] d, input logic clr,
                                input logic v, input logic [DW-1:0] ed, input logic es,
                                input logic eo, input logic ec);
        vec_t r;
        r.en = en; r.data = d; r.clr = clr;
        r.e_valid = v; r.e_data = ed; r.e_src = es; r.e_ovf = eo; r.e_cont = ec;
        vecs.push_back(r);
    endfunction

    // Scoreboard: every accepted pop must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no entry", {out_src, out_data});
            end else begin
                mon_exp = sb_q.pop_front();
                chk("pop_entry", 32'({out_src, out_data}), 32'(mon_exp));
            end
        end
    end

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (out_valid || sb_q.size() != 0); i++) step();
        out_ready = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_sb_left", 32'(sb_q.size()), 32'd0);
    endtask

    // Holds one one-hot enable for SETTLE+1 edges, optional pop on the capture edge
    task automatic capture(input logic src, input logic [DW-1:0] d, input logic rdy_cap);
        bus_en   = src ? 2'b10 : 2'b01;
        bus_data = d;
        for (int i = 0; i < SETTLE; i++) step();
        out_ready = rdy_cap;
        step();
        out_ready = 1'b0;
        bus_en    = 2'b00;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus_data = '0; bus_en = 2'b00; out_ready = 1'b0; clr_err = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cont", 32'(contention), 32'd0);
        rst_n = 1'b1;

        // enable of driver 1 dropped before settling: no capture
        add(2'b10, 8'h5A, 0, 0, 8'h00, 0, 0, 0);
        add(2'b10, 8'h5A, 0, 0, 8'h00, 0, 0, 0);
        add(2'b00, 8'h5A, 0, 0, 8'h00, 0, 0, 0);
        // switch to the other one-hot mid-settle aborts
        add(2'b01, 8'h11, 0, 0, 8'h00, 0, 0, 0);
        add(2'b01, 8'h11, 0, 0, 8'h00, 0, 0, 0);
        add(2'b10, 8'h11, 0, 0, 8'h00, 0, 0, 0);
        add(2'b00, 8'h11, 0, 0, 8'h00, 0, 0, 0);
        // contention, clear, and set-wins-over-clear
        add(2'b11, 8'h22, 0, 0, 8'h00, 0, 0, 1);
        add(2'b00, 8'h22, 0, 0, 8'h00, 0, 0, 1);
        add(2'b00, 8'h22, 1, 0, 8'h00, 0, 0, 0);
        add(2'b11, 8'h22, 1, 0, 8'h00, 0, 0, 1);
        add(2'b00, 8'h22, 1, 0, 8'h00, 0, 0, 0);
        // capture on the third edge, then a long hold yields nothing more
        add(2'b01, 8'hA5, 0, 0, 8'h00, 0, 0, 0);
        add(2'b01, 8'hA5, 0, 0, 8'h00, 0, 0, 0);
        add(2'b01, 8'hA5, 0, 1, 8'hA5, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(2'b01, 8'h3C, 0, 1, 8'hA5, 0, 0, 0);
        add(2'b00, 8'h3C, 0, 1, 8'hA5, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus_en   = vecs[i].en;
            bus_data = vecs[i].data;
            clr_err  = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_src", i), 32'(out_src), 32'(vecs[i].e_src));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d_cont", i), 32'(contention), 32'(vecs[i].e_cont));
        end
        clr_err = 1'b0;
        bus_en  = 2'b00;
        sb_q.push_back({1'b0, 8'hA5});
        drain();

        // five captures into a four-deep FIFO
        for (int k = 1; k <= 5; k++) begin
            capture(1'(k % 2), 8'(k), 1'b0);
            if (k <= DEPTH) sb_q.push_back({1'(k % 2), 8'(k)});
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("full_head", 32'({out_src, out_data}), 32'h101);
        drain();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // capture into a full FIFO with a simultaneous pop
        for (int k = 1; k <= DEPTH; k++) begin
            capture(1'b0, 8'(8'h10 + k), 1'b0);
            sb_q.push_back({1'b0, 8'(8'h10 + k)});
        end
        sb_q.push_back({1'b1, 8'h20});
        capture(1'b1, 8'h20, 1'b1);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        chk("fullpop_head", 32'({out_src, out_data}), 32'h012);
        chk("fullpop_sb", 32'(sb_q.size()), 32'(DEPTH));
        drain();

        // reset mid-settle with two entries queued and contention set
        capture(1'b0, 8'h31, 1'b0);
        capture(1'b1, 8'h32, 1'b0);
        bus_en = 2'b11;
        step();
        chk("pre_rst_cont", 32'(contention), 32'd1);
        bus_en = 2'b00;
        step();
        bus_en = 2'b01;
        bus_data = 8'h77;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        sb_q.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_src", 32'(out_src), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_cont", 32'(contention), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_e1", 32'(out_valid), 32'd0);
        step();
        chk("post_rst_e2", 32'(out_valid), 32'd0);
        step();
        chk("post_rst_e3_valid", 32'(out_valid), 32'd1);
        chk("post_rst_e3_head", 32'({out_src, out_data}), 32'h077);
        bus_en = 2'b00;
        sb_q.push_back({1'b0, 8'h77});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tri_bus_reader.md
TRI_BUS_READER -- requirements
Module: tri_bus_reader

Interface
REQ-001 Parameter DW, default 8: width of the shared tristate data bus.
REQ-002 Parameter SETTLE, default 2 (legal 1..15): number of cycles to wait between enable-stable detection and data capture.
REQ-003 Parameter DEPTH, default 4 (power of two, at least 2): number of capture FIFO entries.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 bus_data  input  DW: resolved value of the shared tristate bus.
REQ-007 bus_en  input  2: copies of the enables of the two tristate drivers on the bus (bit0 = driver 0, bit1 = driver 1).
REQ-008 out_data  output  DW: data of the FIFO head entry.
REQ-009 out_src  output  1: driver index of the FIFO head entry.
REQ-010 out_valid  output  1: high when the FIFO is not empty.
REQ-011 out_ready  input  1: consumer accept; a pop occurs when out_valid and out_ready are both high.
REQ-012 overflow  output  1: sticky flag; set when a capture is dropped.
REQ-013 contention  output  1: sticky flag; set when both drivers are enabled at once.
REQ-014 clr_err  input  1: clears overflow and contention.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE and HOLD; all inputs are sampled on the rising clk edge.
REQ-016 IDLE: on sampling bus_en = 01 or 10, the block SHALL latch that value, set the settle counter to 1 and go to SETTLE; on sampling 00, it SHALL stay in IDLE.
REQ-017 SETTLE, same bus_en value sampled, counter < SETTLE: the counter SHALL increment.
REQ-018 SETTLE, same bus_en value sampled, counter == SETTLE: the block SHALL capture {latched src, bus_data} into the FIFO and go to HOLD.
REQ-019 Capture timing: capture SHALL occur at the (SETTLE+1)th consecutive edge at which the same one-hot enable is sampled; bus_data is sampled at that same edge.
REQ-020 SETTLE, bus_en sampled as 00 or as the other one-hot value: the block SHALL abort to IDLE with no capture and no flag.
REQ-021 HOLD: the block SHALL stay in HOLD until bus_en = 00 is sampled, then go to IDLE; each enable assertion yields at most one capture.
REQ-022 bus_en = 11 sampled in any state: contention SHALL be set and the FSM SHALL go to HOLD with no capture.
REQ-023 out_valid SHALL rise on the edge that pushes into an empty FIFO, so a capture is visible one edge after sampling.
REQ-024 out_data/out_src SHALL always present the head entry; there is no fall-through beyond the register write.
REQ-025 FIFO order is first-in first-out; read and write pointers wrap modulo DEPTH.
REQ-026 Capture when FIFO full and no pop that cycle: the entry SHALL be dropped, overflow set, and FIFO contents unchanged.
REQ-027 Capture when full with a simultaneous pop: both SHALL complete, count stays DEPTH, overflow is not set.
REQ-028 Pop when empty SHALL be ignored.
REQ-029 clr_err SHALL clear both flags at the edge; if a set event occurs in the same cycle, the set SHALL win.

Reset
REQ-030 rst_n low at an edge SHALL force: state IDLE, settle counter 0, FIFO pointers and count 0, out_valid 0, overflow 0, contention 0, out_data 0, out_src 0.
REQ-031 Reset asserted mid-SETTLE or in HOLD SHALL discard the pending capture and FIFO contents.
REQ-032 After reset release, the first edge SHALL evaluate bus_en as in IDLE.

Verification
REQ-033 SETTLE=2, bus_en=01 for 3 edges, bus_data=8'hA5, out_ready=0 -> after 3rd edge out_valid=1, out_data=A5, out_src=0; bus_en held 10 more cycles -> no second entry.
REQ-034 bus_en=10 for 2 edges then 00 -> no capture, out_valid stays 0, flags 0.
REQ-035 bus_en=11 for one edge -> contention=1, no capture; clr_err pulse -> contention=0.
REQ-036 Five captures (data 01..05, out_ready=0, DEPTH=4) -> 4 entries, overflow=1; pops return 01,02,03,04, then out_valid=0.
REQ-037 FIFO full, capture coinciding with out_ready=1 -> pop returns oldest, new entry stored, overflow stays 0.
REQ-038 rst_n low during SETTLE with FIFO holding 2 entries -> next cycle out_valid=0, no capture, all flags 0.
